// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and master controller state encodings.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/axi4_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one command into a full write or
// read transaction, collects the response and aborts on a per-command timeout.
//
// state    | meaning
// IDLE     | cmd_ready high, waiting for a command
// WR_REQ   | awvalid/wvalid held until each handshake completes
// WR_RESP  | bready high, waiting for bvalid
// RD_REQ   | arvalid held until arready
// RD_RESP  | rready high, waiting for rvalid
// RESP     | one-cycle rsp_valid pulse
module axi4_lite_master_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  PROT           = 3'b000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD =
        (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done_q, w_done_q;
    logic [TMR_W-1:0]  timer_q;
    logic [31:0]       rsp_rdata_q;
    logic [1:0]        rsp_resp_q;

    logic accept, active, tmo, abort;
    logic aw_hs, w_hs, wr_req_done;

    assign accept      = (state_q == ST_IDLE) && cmd_valid;
    assign active      = (state_q != ST_IDLE) && (state_q != ST_RESP);
    assign aw_hs       = (state_q == ST_WR_REQ) && !aw_done_q && awready;
    assign w_hs        = (state_q == ST_WR_REQ) && !w_done_q && wready;
    assign wr_req_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

    // Down-counter reaches zero on the last allowed cycle; a handshake that
    // lets the state advance in that cycle wins over the abort.
    assign tmo   = (TIMEOUT_CYCLES != 0) && (timer_q == '0);
    assign abort = tmo && (((state_q == ST_WR_REQ)  && !wr_req_done) ||
                           ((state_q == ST_WR_RESP) && !bvalid)      ||
                           ((state_q == ST_RD_REQ)  && !arready)     ||
                           ((state_q == ST_RD_RESP) && !rvalid));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_valid) state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
            ST_WR_REQ:  if (wr_req_done) state_d = ST_WR_RESP;
                        else if (abort)  state_d = ST_RESP;
            ST_WR_RESP: if (bvalid || abort) state_d = ST_RESP;
            ST_RD_REQ:  if (arready)   state_d = ST_RD_RESP;
                        else if (abort) state_d = ST_RESP;
            ST_RD_RESP: if (rvalid || abort) state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_resp  = RESP_OKAY;
        case (state_q)
            ST_IDLE:    cmd_ready = 1'b1;
            ST_WR_REQ: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
            end
            ST_WR_RESP: bready  = 1'b1;
            ST_RD_REQ:  arvalid = 1'b1;
            ST_RD_RESP: rready  = 1'b1;
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rsp_rdata_q;
                rsp_resp  = rsp_resp_q;
            end
            default: ;
        endcase
    end

    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign awprot = PROT;
    assign arprot = PROT;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            timer_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else if (accept) begin
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            timer_q     <= TMR_LOAD;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (active && (timer_q != '0)) timer_q <= timer_q - 1'b1;
            if ((state_q == ST_WR_RESP) && bvalid) begin
                rsp_resp_q  <= bresp;
                rsp_rdata_q <= '0;
            end else if ((state_q == ST_RD_RESP) && rvalid) begin
                rsp_resp_q  <= rresp;
                rsp_rdata_q <= rdata;
            end else if (abort) begin
                rsp_resp_q  <= RESP_SLVERR;
                rsp_rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Directed bench for axi4_lite_master_ctrl; the slave side is driven cycle by
// cycle with hand-computed expectations (timeout set to 8 cycles).
module tb_axi4_lite_master_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi4_lite_master_ctrl #(.TIMEOUT_CYCLES(8), .PROT(3'b000)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    initial begin
        aresetn = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;

        // reset state
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_awvalid",   32'(awvalid),   32'h0);
        chk("rst_wvalid",    32'(wvalid),    32'h0);
        chk("rst_arvalid",   32'(arvalid),   32'h0);
        chk("rst_bready",    32'(bready),    32'h0);
        chk("rst_rready",    32'(rready),    32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_resp",  32'(rsp_resp),  32'h0);
        chk("rst_awaddr",    awaddr,         32'h0);
        chk("rst_awprot",    32'(awprot),    32'h0);
        chk("rst_arprot",    32'(arprot),    32'h0);
        aresetn = 1'b1;
        step();

        // zero-wait write
        cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        awready = 1; wready = 1;
        chk("t1_c0_cmd_ready", 32'(cmd_ready), 32'h1);
        step();
        cmd_valid = 0;
        chk("t1_c1_awvalid",   32'(awvalid),   32'h1);
        chk("t1_c1_wvalid",    32'(wvalid),    32'h1);
        chk("t1_c1_awaddr",    awaddr,         32'h10);
        chk("t1_c1_wdata",     wdata,          32'hDEADBEEF);
        chk("t1_c1_wstrb",     32'(wstrb),     32'hF);
        chk("t1_c1_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("t1_c1_bready",    32'(bready),    32'h0);
        bvalid = 1; bresp = 2'b00;
        step();
        chk("t1_c2_bready",  32'(bready),  32'h1);
        chk("t1_c2_awvalid", 32'(awvalid), 32'h0);
        chk("t1_c2_wvalid",  32'(wvalid),  32'h0);
        step();
        bvalid = 0; awready = 0; wready = 0;
        chk("t1_c3_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_c3_rsp_resp",  32'(rsp_resp),  32'h0);
        chk("t1_c3_rsp_rdata", rsp_rdata,      32'h0);
        chk("t1_c3_bready",    32'(bready),    32'h0);
        step();
        chk("t1_c4_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t1_c4_cmd_ready", 32'(cmd_ready), 32'h1);

        // write with awready delayed 3 cycles, wready immediate
        cmd(1'b1, 32'h44, 32'hA5A50F0F, 4'b0011);
        awready = 0; wready = 1;
        step();
        cmd_valid = 0;
        chk("t2_c1_awvalid", 32'(awvalid), 32'h1);
        chk("t2_c1_wvalid",  32'(wvalid),  32'h1);
        step();
        wready = 0;
        chk("t2_c2_wvalid_drop", 32'(wvalid),  32'h0);
        chk("t2_c2_awvalid",     32'(awvalid), 32'h1);
        step();
        chk("t2_c3_awvalid", 32'(awvalid), 32'h1);
        chk("t2_c3_awaddr",  awaddr,       32'h44);
        step();
        awready = 1;
        chk("t2_c4_awvalid", 32'(awvalid), 32'h1);
        chk("t2_c4_bready",  32'(bready),  32'h0);
        step();
        awready = 0;
        chk("t2_c5_awvalid", 32'(awvalid), 32'h0);
        chk("t2_c5_bready",  32'(bready),  32'h1);
        bvalid = 1; bresp = 2'b01;
        step();
        bvalid = 0;
        chk("t2_c6_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t2_c6_rsp_resp",  32'(rsp_resp),  32'h1);
        chk("t2_c6_bready",    32'(bready),    32'h0);
        step();
        chk("t2_c7_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t2_c7_cmd_ready", 32'(cmd_ready), 32'h1);

        // read with 2 response wait cycles, SLVERR from slave
        cmd(1'b0, 32'h20, 32'h0, 4'h0);
        arready = 1;
        step();
        cmd_valid = 0;
        chk("t3_c1_arvalid", 32'(arvalid), 32'h1);
        chk("t3_c1_araddr",  araddr,       32'h20);
        chk("t3_c1_awvalid", 32'(awvalid), 32'h0);
        step();
        arready = 0;
        chk("t3_c2_arvalid", 32'(arvalid), 32'h0);
        chk("t3_c2_rready",  32'(rready),  32'h1);
        step();
        chk("t3_c3_rready",    32'(rready),    32'h1);
        chk("t3_c3_rsp_valid", 32'(rsp_valid), 32'h0);
        step();
        rvalid = 1; rdata = 32'h12345678; rresp = 2'b10;
        chk("t3_c4_rready", 32'(rready), 32'h1);
        step();
        rvalid = 0; rdata = '0; rresp = '0;
        chk("t3_c5_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t3_c5_rsp_rdata", rsp_rdata,      32'h12345678);
        chk("t3_c5_rsp_resp",  32'(rsp_resp),  32'h2);
        step();
        chk("t3_c6_rsp_rdata",  rsp_rdata,      32'h0);
        chk("t3_c6_cmd_ready",  32'(cmd_ready), 32'h1);

        // timeout: arready stuck low
        cmd(1'b0, 32'h40, 32'h0, 4'h0);
        arready = 0;
        step();
        cmd_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t4_c%0d_arvalid", i), 32'(arvalid), 32'h1);
            step();
        end
        chk("t4_c9_arvalid",   32'(arvalid),   32'h0);
        chk("t4_c9_rready",    32'(rready),    32'h0);
        chk("t4_c9_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t4_c9_rsp_resp",  32'(rsp_resp),  32'h2);
        chk("t4_c9_rsp_rdata", rsp_rdata,      32'h0);
        step();
        chk("t4_c10_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("t4_c10_rsp_valid", 32'(rsp_valid), 32'h0);

        // arready arrives on the last allowed cycle: handshake beats timeout
        cmd(1'b0, 32'h50, 32'h0, 4'h0);
        step();
        cmd_valid = 0;
        for (int i = 1; i <= 7; i++) step();
        arready = 1;
        chk("t5_c8_arvalid", 32'(arvalid), 32'h1);
        step();
        arready = 0;
        chk("t5_c9_arvalid",   32'(arvalid),   32'h0);
        chk("t5_c9_rready",    32'(rready),    32'h1);
        chk("t5_c9_rsp_valid", 32'(rsp_valid), 32'h0);
        rvalid = 1; rdata = 32'h0BADF00D; rresp = 2'b00;
        step();
        rvalid = 0; rdata = '0;
        chk("t5_c10_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t5_c10_rsp_rdata", rsp_rdata,      32'h0BADF00D);
        chk("t5_c10_rsp_resp",  32'(rsp_resp),  32'h0);
        step();

        // reset during WR_RESP, then a normal read
        cmd(1'b1, 32'h60, 32'h11223344, 4'hF);
        awready = 1; wready = 1;
        step();
        cmd_valid = 0;
        step();
        awready = 0; wready = 0;
        chk("t6_c2_bready", 32'(bready), 32'h1);
        #3;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_bready",    32'(bready),    32'h0);
        chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t6_rst_awaddr",    awaddr,         32'h0);
        step();
        chk("t6_rst_hold_rsp_valid", 32'(rsp_valid), 32'h0);
        #3;
        aresetn = 1'b1;
        step();
        chk("t6_post_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t6_post_cmd_ready", 32'(cmd_ready), 32'h1);
        cmd(1'b0, 32'h70, 32'h0, 4'h0);
        arready = 1;
        step();
        cmd_valid = 0;
        chk("t6_c1_arvalid", 32'(arvalid), 32'h1);
        chk("t6_c1_araddr",  araddr,       32'h70);
        chk("t6_c1_rready",  32'(rready),  32'h0);
        rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b00;
        step();
        arready = 0;
        chk("t6_c2_rready", 32'(rready), 32'h1);
        step();
        rvalid = 0; rdata = '0;
        chk("t6_c3_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t6_c3_rsp_rdata", rsp_rdata,      32'hCAFEF00D);
        chk("t6_c3_rsp_resp",  32'(rsp_resp),  32'h0);
        step();
        chk("t6_c4_cmd_ready", 32'(cmd_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
